// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================
// bp_pkg : shared types/constants for the predictor update path
// Rev 1.0
// ============================================================
package bp_pkg;

  localparam int BP_UPD_W         = 59;
  localparam int BP_TABLE_ENTRIES = 32;
  localparam int BP_DROP_W        = 8;

  typedef struct packed {
    logic [BP_UPD_W-3:0] payload;
    logic                taken;
    logic                valid;
  } BPUpdate;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } SchedState;

endpackage
`default_nettype wire

// File: rtl/bp_update_fifo.sv
`default_nettype none
// ============================================================
// bp_update_fifo : NUM_IN-write / 1-read circular buffer with drop counter
// Rev 1.0
// ============================================================
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 4,
  parameter int UPD_W  = BP_UPD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_en_i,
  input  logic [NUM_IN-1:0]         valid_i,
  input  logic [NUM_IN*UPD_W-1:0]   data_i,
  input  logic                      deq_i,
  output logic [UPD_W-1:0]          head_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [$clog2(DEPTH):0]    count_next_o,
  output logic [BP_DROP_W-1:0]      drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [UPD_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     free_w, n_acc_w, n_drop_w;
  logic [NUM_IN-1:0]    acc_w;
  logic [PTR_W-1:0]     slot_w [NUM_IN];
  logic [BP_DROP_W-1:0] drop_q, drop_d;
  logic [BP_DROP_W:0]   drop_sum_w;

  // Free space comes from the start-of-cycle count, so a slot vacated by
  // this cycle's dequeue cannot be refilled until the next cycle.
  always_comb begin
    free_w   = CNT_W'(DEPTH) - count_q;
    n_acc_w  = '0;
    n_drop_w = '0;
    acc_w    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      slot_w[i] = tail_q + n_acc_w[PTR_W-1:0];
      if (enq_en_i && valid_i[i]) begin
        if (n_acc_w < free_w) begin
          acc_w[i] = 1'b1;
          n_acc_w  = n_acc_w + 1'b1;
        end else begin
          n_drop_w = n_drop_w + 1'b1;
        end
      end
    end
    count_d    = count_q + n_acc_w - {{(CNT_W-1){1'b0}}, deq_i};
    drop_sum_w = {1'b0, drop_q} + (BP_DROP_W+1)'(n_drop_w);
    drop_d     = drop_sum_w[BP_DROP_W] ? {BP_DROP_W{1'b1}} : drop_sum_w[BP_DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(deq_i);
      tail_q  <= tail_q + n_acc_w[PTR_W-1:0];
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (acc_w[i]) mem_q[slot_w[i]] <= data_i[i*UPD_W +: UPD_W];
    end
  end

  assign head_o       = mem_q[head_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign drop_cnt_o   = drop_q;

endmodule
`default_nettype wire

// File: rtl/bp_update_scheduler.sv
`default_nettype none
// ============================================================
// bp_update_scheduler : buffers predictor updates, owns the table-clear walk
// Rev 1.0
// ============================================================
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int NUM_IN      = 2,
  parameter int DEPTH       = 4,
  parameter int NUM_ENTRIES = BP_TABLE_ENTRIES,
  parameter int UPD_W       = BP_UPD_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           IN_clear,
  input  logic                           IN_mispredFlush,
  input  logic [NUM_IN-1:0]              IN_updValid,
  input  logic [NUM_IN*UPD_W-1:0]        IN_upd,
  output logic                           OUT_stall,
  output logic                           OUT_updValid,
  output logic [UPD_W-1:0]               OUT_upd,
  output logic                           OUT_clrValid,
  output logic [$clog2(NUM_ENTRIES)-1:0] OUT_clrIdx,
  output logic                           OUT_busy,
  output logic [BP_DROP_W-1:0]           OUT_dropCnt
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  SchedState        state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             upd_valid_q;
  logic [UPD_W-1:0] upd_q;
  logic             stall_q, stall_d;
  logic             deq_w;
  logic [UPD_W-1:0] head_w;
  logic [CNT_W-1:0] count_w, count_next_w;

  bp_update_fifo #(
    .NUM_IN (NUM_IN),
    .DEPTH  (DEPTH),
    .UPD_W  (UPD_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .enq_en_i     (~IN_mispredFlush),
    .valid_i      (IN_updValid),
    .data_i       (IN_upd),
    .deq_i        (deq_w),
    .head_o       (head_w),
    .count_o      (count_w),
    .count_next_o (count_next_w),
    .drop_cnt_o   (OUT_dropCnt)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    deq_w     = 1'b0;
    case (state_q)
      RUN: begin
        if (IN_clear) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else begin
          deq_w = (count_w != '0);
        end
      end
      CLEAR: begin
        if (IN_clear) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
          state_d   = RUN;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
    // Sources need room for a full NUM_IN-wide burst next cycle.
    stall_d = ((CNT_W'(DEPTH) - count_next_w) < CNT_W'(NUM_IN)) || (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      upd_valid_q <= 1'b0;
      upd_q       <= '0;
      stall_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      upd_valid_q <= deq_w;
      stall_q     <= stall_d;
      if (deq_w) upd_q <= head_w;
    end
  end

  assign OUT_stall    = stall_q;
  assign OUT_updValid = upd_valid_q;
  assign OUT_upd      = upd_q;
  assign OUT_clrValid = (state_q == CLEAR);
  assign OUT_busy     = (state_q == CLEAR);
  assign OUT_clrIdx   = clr_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_update_scheduler.sv
`default_nettype none
// ============================================================
// tb_bp_update_scheduler : directed + random bench against a queue-based model
// Rev 1.0
// ============================================================
module tb_bp_update_scheduler;

  localparam int NUM_IN      = 2;
  localparam int DEPTH       = 4;
  localparam int NUM_ENTRIES = 32;
  localparam int UPD_W       = 59;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, clr, flush;
  logic [NUM_IN-1:0]       vld;
  logic [UPD_W-1:0]        rec [NUM_IN];
  logic [NUM_IN*UPD_W-1:0] upd_bus;
  assign upd_bus = {rec[1], rec[0]};

  logic             OUT_stall, OUT_updValid, OUT_clrValid, OUT_busy;
  logic [UPD_W-1:0] OUT_upd;
  logic [4:0]       OUT_clrIdx;
  logic [7:0]       OUT_dropCnt;

  bp_update_scheduler #(
    .NUM_IN(NUM_IN), .DEPTH(DEPTH), .NUM_ENTRIES(NUM_ENTRIES), .UPD_W(UPD_W)
  ) dut (
    .clk(clk), .rst(rst), .IN_clear(clr), .IN_mispredFlush(flush),
    .IN_updValid(vld), .IN_upd(upd_bus),
    .OUT_stall(OUT_stall), .OUT_updValid(OUT_updValid), .OUT_upd(OUT_upd),
    .OUT_clrValid(OUT_clrValid), .OUT_clrIdx(OUT_clrIdx), .OUT_busy(OUT_busy),
    .OUT_dropCnt(OUT_dropCnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a queue of pending records plus walk position.
  logic [UPD_W-1:0] mq [$];
  bit               m_clear;
  int               m_idx, m_drop;
  bit               m_valid, m_stall;
  logic [UPD_W-1:0] m_upd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [UPD_W-1:0] incoming [$];
    int  free, drops;
    bit  deq;
    if (rst) begin
      mq.delete();
      m_clear = 1; m_idx = 0; m_valid = 0; m_upd = '0; m_drop = 0; m_stall = 1;
      return;
    end
    deq   = !m_clear && !clr && (mq.size() > 0);
    free  = DEPTH - mq.size();
    drops = 0;
    if (!flush) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (vld[i]) begin
          if (free > 0) begin incoming.push_back(rec[i]); free--; end
          else drops++;
        end
      end
    end
    m_drop  = (m_drop + drops > 255) ? 255 : m_drop + drops;
    m_valid = deq;
    if (deq) m_upd = mq.pop_front();
    foreach (incoming[k]) mq.push_back(incoming[k]);
    if (!m_clear) begin
      if (clr) begin m_clear = 1; m_idx = 0; end
    end else if (clr) begin
      m_idx = 0;
    end else if (m_idx == NUM_ENTRIES - 1) begin
      m_clear = 0; m_idx = 0;
    end else begin
      m_idx++;
    end
    m_stall = ((DEPTH - mq.size()) < NUM_IN) || m_clear;
  endtask

  task automatic check_outputs();
    check("clrValid", OUT_clrValid, m_clear);
    check("busy", OUT_busy, m_clear);
    if (m_clear) check("clrIdx", OUT_clrIdx, m_idx);
    check("updValid", OUT_updValid, m_valid);
    check("upd", OUT_upd, m_upd);
    check("stall", OUT_stall, m_stall);
    check("dropCnt", OUT_dropCnt, m_drop);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic randomize_recs();
    for (int i = 0; i < NUM_IN; i++) rec[i] = UPD_W'({$urandom, $urandom});
  endtask

  logic [UPD_W-1:0] rec_a, rec_b, r0, r1, r2;
  int cyc, guard, upd_seen;

  initial begin
    rec_a = 59'h1AB_CDEF_0123_4567;
    rec_b = 59'h2FE_DCBA_9876_5433;
    rst = 1; clr = 0; flush = 0; vld = '0; rec[0] = '0; rec[1] = '0;
    tick(); tick();
    rst = 0;

    // Post-reset walk: 32 clear cycles, indices in order, no updates.
    cyc = 0; upd_seen = 0; guard = 0;
    while (OUT_clrValid && guard < 100) begin
      check("walk_idx", OUT_clrIdx, cyc[4:0]);
      upd_seen += OUT_updValid;
      cyc++; guard++;
      tick();
    end
    check("walk_len", cyc, 32);
    check("walk_upd", upd_seen, 0);

    // Dual enqueue in one cycle drains in source order.
    rec[0] = rec_a; rec[1] = rec_b; vld = 2'b11;
    tick();
    vld = '0;
    tick();
    check("t2_a_valid", OUT_updValid, 1);
    check("t2_a", OUT_upd, rec_a);
    tick();
    check("t2_b_valid", OUT_updValid, 1);
    check("t2_b", OUT_upd, rec_b);
    tick();
    check("t2_idle", OUT_updValid, 0);
    check("t2_drop", OUT_dropCnt, 0);

    // Overdrive: both sources for three cycles, stall ignored.
    for (int k = 0; k < 3; k++) begin
      randomize_recs(); vld = 2'b11;
      tick();
    end
    vld = '0;
    repeat (6) tick();

    // Clear with three records queued; restart at index 10.
    randomize_recs(); r0 = rec[0]; r1 = rec[1]; vld = 2'b11;
    tick();
    randomize_recs(); r2 = rec[0]; vld = 2'b01; clr = 1;
    tick();
    vld = '0; clr = 0;
    upd_seen = 0;
    for (int k = 0; k < 10; k++) begin
      upd_seen += OUT_updValid;
      tick();
    end
    check("t4_idx10", OUT_clrIdx, 10);
    clr = 1;
    tick();
    clr = 0;
    check("t4_restart", OUT_clrIdx, 0);
    cyc = 0; guard = 0;
    while (OUT_clrValid && guard < 100) begin
      upd_seen += OUT_updValid;
      cyc++; guard++;
      tick();
    end
    check("t4_walk_len", cyc, 32);
    check("t4_no_upd", upd_seen, 0);
    tick();
    check("t4_r0", OUT_upd, r0);
    tick();
    check("t4_r1", OUT_upd, r1);
    tick();
    check("t4_r2", OUT_upd, r2);
    check("t4_r2_valid", OUT_updValid, 1);

    // Flush suppresses enqueue while queued records drain.
    randomize_recs(); vld = 2'b11;
    tick();
    flush = 1;
    repeat (2) begin randomize_recs(); tick(); end
    flush = 0; vld = '0;
    repeat (4) tick();

    // Drop saturation: hold the walk so nothing drains.
    clr = 1; vld = 2'b11;
    repeat (152) begin randomize_recs(); tick(); end
    check("t6_sat", OUT_dropCnt, 255);
    clr = 0; vld = '0;
    repeat (5) tick();
    check("t6_mid_idx", OUT_clrIdx, 5);
    rst = 1;
    tick();
    rst = 0;
    check("t6_rst_idx", OUT_clrIdx, 0);
    check("t6_rst_drop", OUT_dropCnt, 0);
    guard = 0;
    while (OUT_clrValid && guard < 100) begin guard++; tick(); end
    check("t6_walk_done", OUT_clrValid, 0);
    upd_seen = 0;
    repeat (4) begin tick(); upd_seen += OUT_updValid; end
    check("t6_fifo_empty", upd_seen, 0);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      rst   = ($urandom_range(0, 299) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      vld   = NUM_IN'($urandom_range(0, 3));
      randomize_recs();
      tick();
    end
    rst = 0; clr = 0; flush = 0; vld = '0;
    repeat (60) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
